// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle between N byte sources, the round-robin merger and the shared FIFO input.
// With AXIS_ARB_LAST_EN defined the bundle also carries per-port ilast and the merged olast.
// The slave modport is the arbiter's view of the bundle; the master modport is its environment's view.
interface axis_rr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2
);
    localparam int PORTS = 1 << SEL_WIDTH;

    logic [PORTS*DATA_WIDTH-1:0] idata;
    logic [PORTS-1:0]            ivalid;
    logic [PORTS-1:0]            iready;
    logic [DATA_WIDTH-1:0]       odata;
    logic                        ovalid;
    logic                        oready;
    logic [SEL_WIDTH-1:0]        osel;
`ifdef AXIS_ARB_LAST_EN
    logic [PORTS-1:0]            ilast;
    logic                        olast;

    modport slave (
        input  idata, ivalid, ilast, oready,
        output iready, odata, ovalid, osel, olast
    );

    modport master (
        output idata, ivalid, ilast, oready,
        input  iready, odata, ovalid, osel, olast
    );
`else
    modport slave (
        input  idata, ivalid, oready,
        output iready, odata, ovalid, osel
    );

    modport master (
        output idata, ivalid, oready,
        input  iready, odata, ovalid, osel
    );
`endif
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of 2**SEL_WIDTH byte streams into one registered stream; AXIS_ARB_LAST_EN adds packet locking.
// Latency: a beat accepted in cycle n is on odata/ovalid in cycle n+1, one beat per cycle sustained.
// Backpressure: a held output beat (ovalid && !oready) freezes every register and drops all iready.
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2
) (
    input  logic             clock,
    input  logic             resetn,
    axis_rr_arbiter_if.slave bus
);
    localparam int PORTS = 1 << SEL_WIDTH;

    logic                  load;
    logic                  accept;
    logic                  gnt_any;
    logic [SEL_WIDTH-1:0]  gnt_sel;
    logic [SEL_WIDTH-1:0]  scan_idx;
    logic [PORTS-1:0]      iready_d;

    logic [DATA_WIDTH-1:0] odata_q,  odata_d;
    logic                  ovalid_q, ovalid_d;
    logic [SEL_WIDTH-1:0]  osel_q,   osel_d;
    logic [SEL_WIDTH-1:0]  ptr_q,    ptr_d;
`ifdef AXIS_ARB_LAST_EN
    logic                  olast_q,  olast_d;
    logic                  lock_q,   lock_d;
    logic [SEL_WIDTH-1:0]  lock_sel_q, lock_sel_d;
`endif

    assign load   = !ovalid_q || bus.oready;
    assign accept = load && gnt_any;

    // Scan from the farthest offset down so the port nearest ptr is the last (winning) assignment.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_sel  = ptr_q;
        scan_idx = ptr_q;
        for (int k = PORTS - 1; k >= 0; k--) begin
            scan_idx = ptr_q + SEL_WIDTH'(k);
            if (bus.ivalid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_sel = scan_idx;
            end
        end
`ifdef AXIS_ARB_LAST_EN
        if (lock_q) begin
            gnt_sel = lock_sel_q;
            gnt_any = bus.ivalid[lock_sel_q];
        end
`endif
    end

    always_comb begin
        iready_d = '0;
        if (accept) begin
            iready_d[gnt_sel] = 1'b1;
        end
    end

    assign bus.iready = iready_d;

    always_comb begin
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        osel_d   = osel_q;
        ptr_d    = ptr_q;
`ifdef AXIS_ARB_LAST_EN
        olast_d    = olast_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
`endif
        if (load) begin
            ovalid_d = gnt_any;
            if (gnt_any) begin
                odata_d = bus.idata[int'(gnt_sel)*DATA_WIDTH +: DATA_WIDTH];
                osel_d  = gnt_sel;
`ifdef AXIS_ARB_LAST_EN
                olast_d = bus.ilast[gnt_sel];
                // The pointer only moves once a whole packet has gone through.
                if (bus.ilast[gnt_sel]) begin
                    lock_d = 1'b0;
                    ptr_d  = gnt_sel + SEL_WIDTH'(1);
                end else begin
                    lock_d     = 1'b1;
                    lock_sel_d = gnt_sel;
                end
`else
                ptr_d   = gnt_sel + SEL_WIDTH'(1);
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            osel_q   <= '0;
            ptr_q    <= '0;
`ifdef AXIS_ARB_LAST_EN
            olast_q    <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
`endif
        end else begin
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            osel_q   <= osel_d;
            ptr_q    <= ptr_d;
`ifdef AXIS_ARB_LAST_EN
            olast_q    <= olast_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
`endif
        end
    end

    assign bus.odata  = odata_q;
    assign bus.ovalid = ovalid_q;
    assign bus.osel   = osel_q;
`ifdef AXIS_ARB_LAST_EN
    assign bus.olast  = olast_q;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter with hand-computed expectations; packet-lock steps run when AXIS_ARB_LAST_EN is defined.
module tb_axis_rr_arbiter;
    logic clock;
    logic resetn;
    int   checks;
    int   errors;

    axis_rr_arbiter_if #(.DATA_WIDTH(8), .SEL_WIDTH(2)) bus ();

    axis_rr_arbiter #(.DATA_WIDTH(8), .SEL_WIDTH(2)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        #3;
        chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
        resetn = 1'b1;
        cyc();
    endtask

    initial begin
        logic [7:0] exp_data [4];
        checks = 0;
        errors = 0;
        exp_data[0] = 8'h10;
        exp_data[1] = 8'h21;
        exp_data[2] = 8'h32;
        exp_data[3] = 8'h43;

        resetn     = 1'b0;
        bus.idata  = '0;
        bus.ivalid = '0;
        bus.oready = 1'b1;
`ifdef AXIS_ARB_LAST_EN
        bus.ilast  = '1;
`endif
        #3;
        chk("reset_ovalid", 32'(bus.ovalid), 32'd0);
        chk("reset_odata",  32'(bus.odata),  32'd0);
        chk("reset_osel",   32'(bus.osel),   32'd0);
        #4 resetn = 1'b1;
        cyc();

        // Idle: nothing requested, nothing produced.
        for (int n = 0; n < 10; n++) begin
            chk("idle_ovalid", 32'(bus.ovalid), 32'd0);
            chk("idle_iready", 32'(bus.iready), 32'd0);
            chk("idle_osel",   32'(bus.osel),   32'd0);
            cyc();
        end

        // All four ports valid: strict rotation 0,1,2,3,0,...
        bus.idata  = 32'h43322110;
        bus.ivalid = 4'b1111;
        #1;
        for (int n = 0; n < 8; n++) begin
            chk("rr_iready", 32'(bus.iready), 32'd1 << (n % 4));
            cyc();
            chk("rr_ovalid", 32'(bus.ovalid), 32'd1);
            chk("rr_odata",  32'(bus.odata),  32'(exp_data[n % 4]));
            chk("rr_osel",   32'(bus.osel),   32'(n % 4));
        end

        // Output held under backpressure after the first beat.
        bus.ivalid = '0;
        do_reset();
        bus.ivalid = 4'b1111;
        bus.oready = 1'b0;
        #1;
        chk("hold_first_iready", 32'(bus.iready), 32'b0001);
        cyc();
        for (int n = 0; n < 3; n++) begin
            chk("hold_ovalid", 32'(bus.ovalid), 32'd1);
            chk("hold_odata",  32'(bus.odata),  32'h10);
            chk("hold_iready", 32'(bus.iready), 32'd0);
            cyc();
        end
        bus.oready = 1'b1;
        #1;
        chk("release_iready", 32'(bus.iready), 32'b0010);
        cyc();
        chk("release_ovalid", 32'(bus.ovalid), 32'd1);
        chk("release_odata",  32'(bus.odata),  32'h21);
        chk("release_osel",   32'(bus.osel),   32'd1);

        // Single requester on port 2 is granted every cycle.
        bus.ivalid = '0;
        do_reset();
        bus.ivalid = 4'b0100;
        for (int n = 0; n < 8; n++) begin
            bus.idata = 32'(n) << 16;
            #1;
            chk("single_iready", 32'(bus.iready), 32'b0100);
            cyc();
            chk("single_ovalid", 32'(bus.ovalid), 32'd1);
            chk("single_odata",  32'(bus.odata),  32'(n));
            chk("single_osel",   32'(bus.osel),   32'd2);
        end
        bus.ivalid = '0;
        cyc();
        chk("single_drain_ovalid", 32'(bus.ovalid), 32'd0);

        // Reset while a beat is held, then the pointer is back at port 0.
        bus.idata  = 32'h43322110;
        bus.ivalid = 4'b1111;
        bus.oready = 1'b0;
        cyc();
        chk("midrst_pre_ovalid", 32'(bus.ovalid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("midrst_osel",   32'(bus.osel),   32'd0);
        #1 resetn = 1'b1;
        bus.oready = 1'b1;
        #1;
        chk("midrst_iready", 32'(bus.iready), 32'b0001);
        cyc();
        chk("midrst_odata", 32'(bus.odata), 32'h10);
        chk("midrst_osel2", 32'(bus.osel),  32'd0);

`ifdef AXIS_ARB_LAST_EN
        // Port 1 sends a 3-beat packet while port 0 streams single-beat packets.
        bus.ivalid = '0;
        do_reset();
        bus.ilast  = 4'b0001;
        bus.idata  = 32'h0000B1A0;
        bus.ivalid = 4'b0011;
        #1;
        chk("pkt_iready0", 32'(bus.iready), 32'b0001);
        cyc();
        chk("pkt_osel0",  32'(bus.osel),  32'd0);
        chk("pkt_olast0", 32'(bus.olast), 32'd1);
        chk("pkt_iready1", 32'(bus.iready), 32'b0010);
        cyc();
        chk("pkt_odata1", 32'(bus.odata), 32'hB1);
        chk("pkt_osel1",  32'(bus.osel),  32'd1);
        chk("pkt_olast1", 32'(bus.olast), 32'd0);
        bus.idata = 32'h0000B2A0;
        #1;
        chk("pkt_iready2", 32'(bus.iready), 32'b0010);
        cyc();
        chk("pkt_odata2", 32'(bus.odata), 32'hB2);
        chk("pkt_osel2",  32'(bus.osel),  32'd1);
        chk("pkt_olast2", 32'(bus.olast), 32'd0);
        bus.idata = 32'h0000B3A0;
        bus.ilast = 4'b0011;
        #1;
        chk("pkt_iready3", 32'(bus.iready), 32'b0010);
        cyc();
        chk("pkt_odata3", 32'(bus.odata), 32'hB3);
        chk("pkt_osel3",  32'(bus.osel),  32'd1);
        chk("pkt_olast3", 32'(bus.olast), 32'd1);
        bus.ivalid = 4'b0001;
        #1;
        chk("pkt_iready4", 32'(bus.iready), 32'b0001);
        cyc();
        chk("pkt_odata4", 32'(bus.odata), 32'hA0);
        chk("pkt_osel4",  32'(bus.osel),  32'd0);
        chk("pkt_olast4", 32'(bus.olast), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
